// File: rtl/dm_cache_main_mem.sv
// Line-granular main-memory model behind the direct-mapped cache: accepts one request,
// answers with a one-cycle ready pulse LATENCY edges later, and keeps read/write stats.
package cache_def;
  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;
endpackage

module dm_cache_main_mem
  import cache_def::*;
#(
  parameter int unsigned DEPTH_LINES = 1024,
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  mem_req_type        mem_req,
  output mem_data_type       mem_data,
  output logic               busy_o,
  output logic [CNT_W-1:0]   rd_count_o,
  output logic [CNT_W-1:0]   wr_count_o
);

  localparam int unsigned IdxW  = $clog2(DEPTH_LINES);
  localparam int unsigned WaitW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               rw_q, rw_d;
  logic [127:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic               accept;
  logic               mem_we;
  logic [IdxW-1:0]    req_idx;
  logic [127:0]       mem_q [DEPTH_LINES];
  logic               unused_addr;

  // Upper address bits wrap; the byte offset within a line is irrelevant.
  assign req_idx     = mem_req.addr[IdxW+3:4];
  assign unused_addr = ^{mem_req.addr[31:IdxW+4], mem_req.addr[3:0]};

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    idx_d    = idx_q;
    rw_d     = rw_q;
    rdata_d  = rdata_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    accept   = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      StIdle: accept = mem_req.valid;
      StBusy: begin
        if (wait_q == '0) begin
          state_d = StResp;
          // Writes were committed at acceptance, so this also echoes written lines.
          rdata_d = mem_q[idx_q];
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
        if (rw_q) begin
          if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else begin
          if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
        // The cache issues its allocate read in the same cycle it sees write-back ready.
        accept = mem_req.valid;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      state_d = StBusy;
      wait_d  = WaitW'(LATENCY - 1);
      idx_d   = req_idx;
      rw_d    = mem_req.rw;
      mem_we  = mem_req.rw;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      idx_q    <= '0;
      rw_q     <= 1'b0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      idx_q    <= idx_d;
      rw_q     <= rw_d;
      rdata_q  <= rdata_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Storage is never reset; gating on reset_ni keeps a held-in-reset request from writing.
  always_ff @(posedge clk_i) begin
    if (mem_we && reset_ni) mem_q[req_idx] <= mem_req.data;
  end

  assign mem_data.data  = rdata_q;
  assign mem_data.ready = (state_q == StResp);
  assign busy_o         = (state_q == StBusy);
  assign rd_count_o     = rd_cnt_q;
  assign wr_count_o     = wr_cnt_q;

endmodule

// File: tb/tb_dm_cache_main_mem.sv
// Directed bench for dm_cache_main_mem: a default instance plus a LATENCY=1, CNT_W=2 instance.
module tb_dm_cache_main_mem;
  import cache_def::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  mem_req_type  req_m, req_s;
  mem_data_type rsp_m, rsp_s;
  logic         busy_m, busy_s;
  logic [15:0]  rdc_m, wrc_m;
  logic [1:0]   rdc_s, wrc_s;
  int           n_checks = 0;
  int           n_fail = 0;

  localparam logic [127:0] DataOnes = {32{4'h1}};
  localparam logic [127:0] DataA    = {32{4'hA}};
  localparam logic [127:0] DataWrap = {16{8'h5A}};
  localparam logic [127:0] DataKeep = {4{32'hDEAD_BEEF}};

  always #5 clk = ~clk;

  dm_cache_main_mem u_dut (
    .clk_i     (clk),
    .reset_ni  (rst_n),
    .mem_req   (req_m),
    .mem_data  (rsp_m),
    .busy_o    (busy_m),
    .rd_count_o(rdc_m),
    .wr_count_o(wrc_m)
  );

  dm_cache_main_mem #(
    .DEPTH_LINES(16),
    .LATENCY    (1),
    .CNT_W      (2)
  ) u_sat (
    .clk_i     (clk),
    .reset_ni  (rst_n),
    .mem_req   (req_s),
    .mem_data  (rsp_s),
    .busy_o    (busy_s),
    .rd_count_o(rdc_s),
    .wr_count_o(wrc_s)
  );

  // Drives a one-cycle request at a negedge; returns edges from acceptance to ready,
  // and busy as seen in the first cycle after acceptance.
  task automatic issue(input logic [31:0] a, input logic [127:0] d, input logic rw,
                       output int lat, output logic busy0);
    req_m.addr  = a;
    req_m.data  = d;
    req_m.rw    = rw;
    req_m.valid = 1'b1;
    @(negedge clk);
    req_m.valid = 1'b0;
    busy0 = busy_m;
    lat = 0;
    while (rsp_m.ready !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_m = '0;
    req_s = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy_m, rsp_m.ready, busy_s, rsp_s.ready} !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: busy/ready=%b required 0000", i,
                 {busy_m, rsp_m.ready, busy_s, rsp_s.ready});
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_m.ready !== 1'b0 || rsp_m.data !== '0 || busy_m !== 1'b0 ||
          rdc_m !== '0 || wrc_m !== '0) begin
        n_fail++;
        $display("FAIL reset_idle_main cyc%0d: ready=%b data=%h busy=%b rd=%0d wr=%0d required 0",
                 i, rsp_m.ready, rsp_m.data, busy_m, rdc_m, wrc_m);
      end
      n_checks++;
      if (rsp_s.ready !== 1'b0 || rsp_s.data !== '0 || busy_s !== 1'b0 ||
          rdc_s !== '0 || wrc_s !== '0) begin
        n_fail++;
        $display("FAIL reset_idle_sat cyc%0d: ready=%b busy=%b rd=%0d wr=%0d required 0",
                 i, rsp_s.ready, busy_s, rdc_s, wrc_s);
      end
    end
  endtask

  task automatic test_write_read;
    int   lat;
    logic b0;
    issue(32'h0000_0120, DataOnes, 1'b1, lat, b0);
    n_checks++;
    if (b0 !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b required 1", b0); end
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL wr_latency: got %0d required 4", lat); end
    n_checks++;
    if (busy_m !== 1'b0) begin n_fail++; $display("FAIL wr_busy_resp: got %b required 0", busy_m); end
    n_checks++;
    if (rsp_m.data !== DataOnes) begin
      n_fail++; $display("FAIL wr_echo: got %h required %h", rsp_m.data, DataOnes);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_m.ready !== 1'b0) begin n_fail++; $display("FAIL wr_pulse: ready %b required 0", rsp_m.ready); end
    n_checks++;
    if (wrc_m !== 16'd1 || rdc_m !== 16'd0) begin
      n_fail++; $display("FAIL wr_count: wr=%0d rd=%0d required 1/0", wrc_m, rdc_m);
    end
    issue(32'h0000_0128, '0, 1'b0, lat, b0);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL rd_latency: got %0d required 4", lat); end
    n_checks++;
    if (rsp_m.data !== DataOnes) begin
      n_fail++; $display("FAIL rd_data: got %h required %h", rsp_m.data, DataOnes);
    end
    @(negedge clk);
    n_checks++;
    if (rdc_m !== 16'd1) begin n_fail++; $display("FAIL rd_count: got %0d required 1", rdc_m); end
    n_checks++;
    if (rsp_m.data !== DataOnes) begin
      n_fail++; $display("FAIL data_hold: got %h required %h", rsp_m.data, DataOnes);
    end
  endtask

  task automatic test_back_to_back;
    int   lat;
    logic b0;
    issue(32'h0000_0200, DataA, 1'b1, lat, b0);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL b2b_wr_latency: got %0d required 4", lat); end
    // Still in the write-back ready cycle: issue the allocate read now.
    issue(32'h0000_0124, '0, 1'b0, lat, b0);
    n_checks++;
    if (b0 !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap: busy %b required 1", b0); end
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL b2b_rd_latency: got %0d required 4", lat); end
    n_checks++;
    if (rsp_m.data !== DataOnes) begin
      n_fail++; $display("FAIL b2b_rd_data: got %h required %h", rsp_m.data, DataOnes);
    end
    @(negedge clk);
    n_checks++;
    if (wrc_m !== 16'd2 || rdc_m !== 16'd2) begin
      n_fail++; $display("FAIL b2b_counts: wr=%0d rd=%0d required 2/2", wrc_m, rdc_m);
    end
    issue(32'h0000_0200, '0, 1'b0, lat, b0);
    n_checks++;
    if (rsp_m.data !== DataA) begin
      n_fail++; $display("FAIL b2b_wr_line: got %h required %h", rsp_m.data, DataA);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    int   lat;
    logic b0;
    issue(32'h0000_4010, DataWrap, 1'b1, lat, b0);
    @(negedge clk);
    issue(32'h0000_0010, '0, 1'b0, lat, b0);
    n_checks++;
    if (rsp_m.data !== DataWrap) begin
      n_fail++; $display("FAIL wrap_data: got %h required %h", rsp_m.data, DataWrap);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int   lat;
    logic b0;
    logic seen;
    // Read accepted, then reset two cycles later.
    req_m.addr = 32'h0000_0120; req_m.rw = 1'b0; req_m.valid = 1'b1;
    @(negedge clk);
    req_m.valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy_m !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", busy_m); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_m.ready === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_ready: ready seen=%b required 0", seen); end
    n_checks++;
    if (rdc_m !== 16'd0 || wrc_m !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_counts: rd=%0d wr=%0d required 0/0", rdc_m, wrc_m);
    end
    // Write committed at acceptance survives a reset before its ready.
    req_m.addr = 32'h0000_0300; req_m.data = DataKeep; req_m.rw = 1'b1; req_m.valid = 1'b1;
    @(negedge clk);
    req_m.valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'h0000_0300, '0, 1'b0, lat, b0);
    n_checks++;
    if (lat != 4 || rsp_m.data !== DataKeep) begin
      n_fail++; $display("FAIL rstmid_write_kept: lat=%0d data=%h required 4/%h", lat, rsp_m.data,
                         DataKeep);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt [5];
    int         lat;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      req_s.addr = 32'h0; req_s.rw = 1'b0; req_s.valid = 1'b1;
      @(negedge clk);
      req_s.valid = 1'b0;
      lat = 0;
      while (rsp_s.ready !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      n_checks++;
      if (lat != 1) begin n_fail++; $display("FAIL sat_latency%0d: got %0d required 1", i, lat); end
      @(negedge clk);
      n_checks++;
      if (rdc_s !== exp_cnt[i]) begin
        n_fail++; $display("FAIL sat_count%0d: got %0d required %0d", i, rdc_s, exp_cnt[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
